// File: rtl/mul_booth_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH-bit operands, signed/unsigned.
// Define MUL_EARLY_OUT_EN to skip the iterations when an operand is zero.
module mul_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res
);

  localparam int N  = WIDTH / 2 + 1;
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   mcand_q;
  logic [WIDTH+2:0] mplr_q;
  logic [CW-1:0]   cnt_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [PW-1:0]   res_q;

  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_d;
  logic [2:0]      dig;
  logic            pos1, pos2, neg1, neg2;
  logic            sx1, sx2;
  logic            accept;

  assign sx1    = is_signed & op1[WIDTH-1];
  assign sx2    = is_signed & op2[WIDTH-1];
  assign accept = in_valid & in_ready_q;

  // mplr_q carries the implicit op2_ext[-1]=0 in its LSB
  assign dig  = mplr_q[2:0];
  assign pos1 = (dig == 3'b001) || (dig == 3'b010);
  assign pos2 = (dig == 3'b011);
  assign neg2 = (dig == 3'b100);
  assign neg1 = (dig == 3'b101) || (dig == 3'b110);

  always_comb begin
    pp = '0;
    unique case (1'b1)
      pos1:    pp = mcand_q;
      pos2:    pp = mcand_q << 1;
      neg2:    pp = -(mcand_q << 1);
      neg1:    pp = -mcand_q;
      default: pp = '0;
    endcase
  end

  assign acc_d = acc_q + pp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q    <= {{WIDTH{sx1}}, op1};
            mplr_q     <= {sx2, sx2, op2, 1'b0};
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
`ifdef MUL_EARLY_OUT_EN
            if ((op1 == '0) || (op2 == '0)) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              res_q       <= '0;
            end else begin
              state_q <= BUSY;
            end
`else
            state_q <= BUSY;
`endif
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q == CW'(N)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            res_q       <= acc_q;
          end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_q << 2;
            mplr_q  <= {mplr_q[WIDTH+2], mplr_q[WIDTH+2],
                        mplr_q[WIDTH+2:2]};
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign res       = res_q;

endmodule

// File: tb/tb_mul_booth_seq.sv
// Bench for mul_booth_seq: WIDTH=32 and WIDTH=8 instances,
// directed cases plus random operands against an arithmetic model.
module tb_mul_booth_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv32, ir32, sg32, ov32, or32;
  logic [31:0] a32, b32;
  logic [63:0] r32;

  logic        iv8, ir8, sg8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;

  int total = 0;
  int bad   = 0;

  mul_booth_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv32), .in_ready(ir32),
    .op1(a32), .op2(b32), .is_signed(sg32),
    .out_valid(ov32), .out_ready(or32), .res(r32)
  );

  mul_booth_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv8), .in_ready(ir8),
    .op1(a8), .op2(b8), .is_signed(sg8),
    .out_valid(ov8), .out_ready(or8), .res(r8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end
    return sa * sb;
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic s);
    int sa, sb;
    sa = s ? int'($signed(a)) : int'(a);
    sb = s ? int'($signed(b)) : int'(b);
    return 16'(sa * sb);
  endfunction

  function automatic int lat_exp(input logic zero, input int n);
`ifdef MUL_EARLY_OUT_EN
    if (zero) return 1;
`endif
    return n + 1;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      3:       return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic start32(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input string tag);
    int w;
    @(negedge clk);
    w = 0;
    while (!ir32 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ir32) chk({tag, " ready"}, 64'(ir32), 64'd1);
    a32 = a; b32 = b; sg32 = s; iv32 = 1'b1;
    @(posedge clk);
    #1;
    iv32 = 1'b0;
    a32 = $urandom; b32 = $urandom; sg32 = ~s;
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b,
                      input logic s, input string tag);
    int lat;
    start32(a, b, s, tag);
    lat = 0;
    while (!ov32 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " lat"}, 64'(lat), 64'(lat_exp(a == 0 || b == 0, 17)));
    chk({tag, " res"}, r32, ref32(a, b, s));
    @(negedge clk);
    or32 = 1'b1;
    @(posedge clk);
    #1;
    or32 = 1'b0;
    chk({tag, " ovfall"}, 64'(ov32), 64'd0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic s, input string tag);
    int w, lat;
    @(negedge clk);
    w = 0;
    while (!ir8 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ir8) chk({tag, " ready"}, 64'(ir8), 64'd1);
    a8 = a; b8 = b; sg8 = s; iv8 = 1'b1;
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 0;
    while (!ov8 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " lat"}, 64'(lat), 64'(lat_exp(a == 0 || b == 0, 5)));
    chk({tag, " res"}, 64'(r8), 64'(ref8(a, b, s)));
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1;
    or8 = 1'b0;
  endtask

  initial begin
    logic [63:0] held;
    rst_n = 1'b1;
    iv32 = 0; sg32 = 0; or32 = 0; a32 = 0; b32 = 0;
    iv8 = 0; sg8 = 0; or8 = 0; a8 = 0; b8 = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst in_ready", 64'(ir32), 64'd0);
    chk("rst out_valid", 64'(ov32), 64'd0);
    chk("rst res", r32, 64'd0);
    chk("rst res8", 64'(r8), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready after rst", 64'(ir32), 64'd1);

    op32(32'd15, 32'd14940, 1'b1, "t1");
    chk("t1 const", r32, 64'h0000_0000_0003_6B64);
    op32(32'd15, 32'hFFFF_C5A4, 1'b1, "t2a");
    chk("t2a const", r32, 64'hFFFF_FFFF_FFFC_949C);
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, "t2b");
    chk("t2b const", r32, 64'h4000_0000_0000_0000);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "t3a");
    chk("t3a const", r32, 64'hFFFF_FFFE_0000_0001);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "t3b");
    chk("t3b const", r32, 64'h1);
    op32(32'h0, 32'h1234_5678, 1'b1, "zero");

    // backpressure in DONE
    start32(32'd15, 32'd14940, 1'b1, "bp");
    for (int i = 0; i < 40 && !ov32; i++) begin
      @(posedge clk);
      #1;
    end
    held = ref32(32'd15, 32'd14940, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iv32 = 1'b1;
      a32 = $urandom; b32 = $urandom;
      chk("bp out_valid", 64'(ov32), 64'd1);
      chk("bp in_ready", 64'(ir32), 64'd0);
      chk("bp res", r32, held);
    end
    @(negedge clk);
    iv32 = 1'b0;
    or32 = 1'b1;
    @(posedge clk);
    #1;
    or32 = 1'b0;
    chk("bp ovfall", 64'(ov32), 64'd0);
    chk("bp ready", 64'(ir32), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp no ghost", 64'(ov32), 64'd0);

    // reset mid-operation
    start32(32'h1234, 32'h5678, 1'b0, "rs");
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rs out_valid", 64'(ov32), 64'd0);
    chk("rs res", r32, 64'd0);
    chk("rs in_ready", 64'(ir32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op32(32'd7, 32'hFFFF_FFFD, 1'b1, "t5");
    chk("t5 const", r32, 64'hFFFF_FFFF_FFFF_FFEB);

    for (int i = 0; i < 30; i++)
      op32(pick32(), pick32(), 1'($urandom_range(0, 1)), "rnd32");

    op8(8'h80, 8'h80, 1'b1, "w8 min");
    chk("w8 min const", 64'(r8), 64'h4000);
    op8(8'hFF, 8'hFF, 1'b0, "w8 max");
    chk("w8 max const", 64'(r8), 64'hFE01);
    op8(8'h00, 8'h5A, 1'b0, "w8 zero");
    for (int i = 0; i < 60; i++)
      op8(pick8(), pick8(), 1'($urandom_range(0, 1)), "rnd8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
